uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with optional even parity.
// Reports each character with a one-cycle word_done strobe and flags parity
// and framing errors. The serial line is synchronised before use, and every
// decision is made on the synchronised copy.
module uart_rx #(
    parameter int CLK_FREQ  = 8000000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY_EN = 0
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       word_done,
    output logic       parity_err,
    output logic       frame_err
);

    // Bit period in clocks (rounded) and half of it, for mid-bit sampling.
    localparam int DIV  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF = DIV / 2;

    // Counter terminal values. The counter runs 0..N-1, so a sample lands
    // exactly N edges after the counter was cleared.
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        rx_meta;
    logic        rxs;

    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_next;

    logic [7:0]  shift;
    logic        shift_en;
    logic        par_bit;
    logic        par_load;
    logic        stop_load;
    logic        stop_bit;
    logic        done_pend;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State, bit counter and bit index registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
        end
    end

    // Next-state logic: decides when to sample and what each sample means.
    always_comb begin
        next_state = state;
        cnt_next   = cnt + 16'd1;
        bit_next   = bit_idx;
        shift_en   = 1'b0;
        par_load   = 1'b0;
        stop_load  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = 16'd0;
                if (rx_en && !rxs) begin
                    next_state = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = 16'd0;
                    bit_next = 3'd0;
                    if (rxs) begin
                        next_state = IDLE;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == DIV_LAST) begin
                    cnt_next = 16'd0;
                    shift_en = 1'b1;
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            next_state = PARITY;
                        end else begin
                            next_state = STOP;
                        end
                    end
                end
            end
            PARITY: begin
                if (cnt == DIV_LAST) begin
                    cnt_next   = 16'd0;
                    par_load   = 1'b1;
                    next_state = STOP;
                end
            end
            STOP: begin
                if (cnt == DIV_LAST) begin
                    cnt_next  = 16'd0;
                    stop_load = 1'b1;
                    if (rxs) begin
                        next_state = IDLE;
                    end else begin
                        next_state = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_next = 16'd0;
                if (rxs) begin
                    next_state = IDLE;
                end
            end
            default: begin
                cnt_next   = 16'd0;
                next_state = IDLE;
            end
        endcase
    end

    // Frame datapath: LSB-first shift register, parity term and stop capture.
    // The stop sample only arms done_pend; outputs update one edge later.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shift     <= 8'h00;
            par_bit   <= 1'b0;
            stop_bit  <= 1'b1;
            done_pend <= 1'b0;
        end else begin
            done_pend <= stop_load;
            if (shift_en) begin
                shift <= {rxs, shift[7:1]};
            end
            if (par_load) begin
                par_bit <= (^shift) ^ rxs;
            end
            if (stop_load) begin
                stop_bit <= rxs;
            end
        end
    end

    // Output registers: strobe for one cycle and hold results until next frame.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_data    <= 8'h00;
            word_done  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_done <= done_pend;
            if (done_pend) begin
                rx_data    <= shift;
                parity_err <= (PARITY_EN != 0) ? par_bit : 1'b0;
                frame_err  <= ~stop_bit;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx, one instance without parity and one
// with even parity, both listening to the same serial line.
module tb_uart_rx;

    localparam int DIV = 69;

    logic       clk_in;
    logic       reset;
    logic       rx;
    logic       rx_en;

    logic [7:0] rx_data_np;
    logic       word_done_np;
    logic       parity_err_np;
    logic       frame_err_np;

    logic [7:0] rx_data_p;
    logic       word_done_p;
    logic       parity_err_p;
    logic       frame_err_p;

    int errors;
    int checks;

    // Each strobe is logged as {frame_err, parity_err, rx_data}.
    logic [9:0] ev_np[$];
    logic [9:0] ev_p[$];

    uart_rx #(
        .CLK_FREQ (8000000),
        .BAUD_RATE(115200),
        .PARITY_EN(0)
    ) u_np (
        .clk_in    (clk_in),
        .reset     (reset),
        .rx        (rx),
        .rx_en     (rx_en),
        .rx_data   (rx_data_np),
        .word_done (word_done_np),
        .parity_err(parity_err_np),
        .frame_err (frame_err_np)
    );

    uart_rx #(
        .CLK_FREQ (8000000),
        .BAUD_RATE(115200),
        .PARITY_EN(1)
    ) u_p (
        .clk_in    (clk_in),
        .reset     (reset),
        .rx        (rx),
        .rx_en     (rx_en),
        .rx_data   (rx_data_p),
        .word_done (word_done_p),
        .parity_err(parity_err_p),
        .frame_err (frame_err_p)
    );

    // 125 ns period, the 8 MHz reference.
    initial clk_in = 1'b0;
    always #62.5 clk_in = ~clk_in;

    // Log every cycle word_done is high, so a stretched strobe shows up twice.
    always @(negedge clk_in) begin
        if (word_done_np === 1'b1) ev_np.push_back({frame_err_np, parity_err_np, rx_data_np});
        if (word_done_p === 1'b1)  ev_p.push_back({frame_err_p, parity_err_p, rx_data_p});
    end

    task automatic hold_line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk_in);
    endtask

    // Drive one frame; drop_at >= 0 deasserts rx_en just before that data bit.
    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par,
                              input logic stop, input int drop_at);
        hold_line(1'b0, DIV);
        for (int i = 0; i < 8; i++) begin
            if (i == drop_at) rx_en = 1'b0;
            hold_line(d[i], DIV);
        end
        if (with_par) hold_line(par, DIV);
        hold_line(stop, DIV);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rx_en = 1'b1;
        for (int i = 0; i < 20; i++) hold_line(logic'(i % 2), 1);
        checks++;
        if ({rx_data_np, word_done_np, parity_err_np, frame_err_np} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_np_outputs: got %h expected 000",
                     {rx_data_np, word_done_np, parity_err_np, frame_err_np});
        end
        checks++;
        if ({rx_data_p, word_done_p, parity_err_p, frame_err_p} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_p_outputs: got %h expected 000",
                     {rx_data_p, word_done_p, parity_err_p, frame_err_p});
        end
        reset = 1'b1;
        hold_line(1'b1, 2 * DIV);
        checks++;
        if ({rx_data_np, parity_err_np, frame_err_np} !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_release_np: got %h expected 000",
                     {rx_data_np, parity_err_np, frame_err_np});
        end
        checks++;
        if (ev_np.size() + ev_p.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_no_strobe: got %0d strobes expected 0",
                     ev_np.size() + ev_p.size());
        end
    endtask

    task automatic test_basic;
        ev_np.delete();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1);
        hold_line(1'b1, 2 * DIV);
        checks++;
        if (ev_np.size() != 1) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d strobe cycles expected 1", ev_np.size());
        end else begin
            checks++;
            if (ev_np[0] !== {2'b00, 8'h55}) begin
                errors++;
                $display("[TB] FAIL basic_frame: got %h expected %h", ev_np[0], {2'b00, 8'h55});
            end
        end
        hold_line(1'b1, 3 * DIV);
        checks++;
        if ({frame_err_np, parity_err_np, rx_data_np} !== {2'b00, 8'h55}) begin
            errors++;
            $display("[TB] FAIL basic_hold: got %h expected %h",
                     {frame_err_np, parity_err_np, rx_data_np}, {2'b00, 8'h55});
        end
    endtask

    task automatic test_back_to_back;
        ev_p.delete();
        // 0xA3 and 0x0F both have four ones, so the even parity bit is 0.
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1, -1);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1);
        hold_line(1'b1, 2 * DIV);
        checks++;
        if (ev_p.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d strobe cycles expected 2", ev_p.size());
        end else begin
            checks++;
            if (ev_p[0] !== {2'b00, 8'hA3}) begin
                errors++;
                $display("[TB] FAIL b2b_first: got %h expected %h", ev_p[0], {2'b00, 8'hA3});
            end
            checks++;
            if (ev_p[1] !== {2'b00, 8'h0F}) begin
                errors++;
                $display("[TB] FAIL b2b_second: got %h expected %h", ev_p[1], {2'b00, 8'h0F});
            end
        end
    endtask

    task automatic test_parity_error;
        ev_p.delete();
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, -1);
        hold_line(1'b1, 2 * DIV);
        checks++;
        if (ev_p.size() != 1) begin
            errors++;
            $display("[TB] FAIL parity_count: got %0d strobe cycles expected 1", ev_p.size());
        end else begin
            checks++;
            if (ev_p[0] !== {2'b01, 8'hA3}) begin
                errors++;
                $display("[TB] FAIL parity_frame: got %h expected %h", ev_p[0], {2'b01, 8'hA3});
            end
        end
        checks++;
        if (parity_err_p !== 1'b1) begin
            errors++;
            $display("[TB] FAIL parity_hold: got %b expected 1", parity_err_p);
        end
    endtask

    task automatic test_framing;
        ev_np.delete();
        // 0x3C ends with a 0 data bit; the line then stays low for 3 bit times.
        hold_line(1'b0, DIV);
        for (int i = 0; i < 8; i++) hold_line(logic'((8'h3C >> i) & 8'h01), DIV);
        hold_line(1'b0, 3 * DIV);
        hold_line(1'b1, 2 * DIV);
        checks++;
        if (ev_np.size() != 1) begin
            errors++;
            $display("[TB] FAIL frame_count: got %0d strobe cycles expected 1", ev_np.size());
        end else begin
            checks++;
            if (ev_np[0] !== {2'b10, 8'h3C}) begin
                errors++;
                $display("[TB] FAIL frame_err_frame: got %h expected %h", ev_np[0], {2'b10, 8'h3C});
            end
        end
        ev_np.delete();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1);
        hold_line(1'b1, 2 * DIV);
        checks++;
        if (ev_np.size() != 1) begin
            errors++;
            $display("[TB] FAIL recover_count: got %0d strobe cycles expected 1", ev_np.size());
        end else begin
            checks++;
            if (ev_np[0] !== {2'b00, 8'h81}) begin
                errors++;
                $display("[TB] FAIL recover_frame: got %h expected %h", ev_np[0], {2'b00, 8'h81});
            end
        end
    endtask

    task automatic test_false_start;
        ev_np.delete();
        ev_p.delete();
        hold_line(1'b0, 10);
        hold_line(1'b1, 12 * DIV);
        checks++;
        if (ev_np.size() + ev_p.size() != 0) begin
            errors++;
            $display("[TB] FAIL glitch_strobe: got %0d strobes expected 0",
                     ev_np.size() + ev_p.size());
        end
        rx_en = 1'b0;
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, -1);
        hold_line(1'b1, 2 * DIV);
        checks++;
        if (ev_np.size() != 0) begin
            errors++;
            $display("[TB] FAIL disabled_strobe: got %0d strobes expected 0", ev_np.size());
        end
        checks++;
        if (rx_data_np !== 8'h81) begin
            errors++;
            $display("[TB] FAIL disabled_hold: got %h expected 81", rx_data_np);
        end
        rx_en = 1'b1;
    endtask

    task automatic test_enable_drop;
        ev_np.delete();
        send_frame(8'h99, 1'b0, 1'b0, 1'b1, 3);
        hold_line(1'b1, 2 * DIV);
        checks++;
        if (ev_np.size() != 1) begin
            errors++;
            $display("[TB] FAIL en_drop_count: got %0d strobe cycles expected 1", ev_np.size());
        end else begin
            checks++;
            if (ev_np[0] !== {2'b00, 8'h99}) begin
                errors++;
                $display("[TB] FAIL en_drop_frame: got %h expected %h", ev_np[0], {2'b00, 8'h99});
            end
        end
        rx_en = 1'b1;
        hold_line(1'b1, DIV);
    endtask

    task automatic test_reset_midframe;
        ev_np.delete();
        // 0xF0: start plus bits 0-3 are low, then bit 4 is high.
        hold_line(1'b0, 5 * DIV);
        hold_line(1'b1, 20);
        reset = 1'b0;
        hold_line(1'b1, 5);
        checks++;
        if (rx_data_np !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_data: got %h expected 00", rx_data_np);
        end
        reset = 1'b1;
        hold_line(1'b1, 8 * DIV);
        checks++;
        if (ev_np.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_strobe: got %0d strobes expected 0", ev_np.size());
        end
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1);
        hold_line(1'b1, 2 * DIV);
        checks++;
        if (ev_np.size() != 1) begin
            errors++;
            $display("[TB] FAIL after_reset_count: got %0d strobe cycles expected 1", ev_np.size());
        end else begin
            checks++;
            if (ev_np[0] !== {2'b00, 8'h12}) begin
                errors++;
                $display("[TB] FAIL after_reset_frame: got %h expected %h", ev_np[0], {2'b00, 8'h12});
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rx     = 1'b1;
        rx_en  = 1'b1;
        reset  = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity_error();
        test_framing();
        test_false_start();
        test_enable_drop();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
